// File: rtl/laser_scheduler.sv
// laser_scheduler: player laser-shot pool.
// Turns the level fire request into cooldown-limited shots, allocates them
// to the lowest free slot, moves active shots up once per frame tick and
// retires them at the top of the screen or on a collision hit.
// Optional build macro: LASER_DOUBLE_SHOT_EN (twin shots at plane_h -/+ 8).
module laser_scheduler #(
    parameter int unsigned SLOTS    = 4,
    parameter int unsigned COOLDOWN = 20,
    parameter int unsigned SPEED    = 3,
    parameter int unsigned START_V  = 400,
    parameter int unsigned TOP_V    = 10,
    parameter int unsigned H_W      = 10,
    parameter int unsigned V_W      = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           state,
    input  logic                 tick,
    input  logic                 fire,
    input  logic [H_W-1:0]       plane_h,
    input  logic [SLOTS-1:0]     hit,
    output logic [SLOTS-1:0]     laser_valid,
    output logic [SLOTS*H_W-1:0] laser_h,
    output logic [SLOTS*V_W-1:0] laser_v,
    output logic                 cooldown_busy,
    output logic [7:0]           shots_fired
);

`ifdef LASER_DOUBLE_SHOT_EN
    localparam int unsigned CD_LOAD = 2 * COOLDOWN;
`else
    localparam int unsigned CD_LOAD = COOLDOWN;
`endif
    localparam int unsigned CNT_W = $clog2(CD_LOAD + 1);

    typedef enum logic [1:0] {
        ST_PRESS_START = 2'd0,
        ST_PLAYING     = 2'd1,
        ST_GAMEOVER    = 2'd2,
        ST_RESTART     = 2'd3
    } game_state_e;

    game_state_e game_state;
    assign game_state = game_state_e'(state);

    logic [SLOTS-1:0]          valid_q, valid_d;
    logic [SLOTS-1:0][H_W-1:0] h_q, h_d;
    logic [SLOTS-1:0][V_W-1:0] v_q, v_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      busy_q, busy_d;
    logic [7:0]                fired_q, fired_d;

    logic [SLOTS-1:0] alloc1;
    logic             found1;
    logic             accept;
    logic [1:0]       n_alloc;
    logic [8:0]       fired_sum;
`ifdef LASER_DOUBLE_SHOT_EN
    logic [SLOTS-1:0] alloc2;
    logic             found2;
`endif

    // Next-state: slot movement/retire, cooldown, fire acceptance, state gating
    always_comb begin
        valid_d = valid_q;
        h_d     = h_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        fired_d = fired_q;
        alloc1  = '0;
        found1  = 1'b0;
`ifdef LASER_DOUBLE_SHOT_EN
        alloc2  = '0;
        found2  = 1'b0;
`endif
        // Free slots are taken from the pre-update valid bits, so a slot
        // retired or hit this cycle cannot be reused until a later tick.
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (!valid_q[i]) begin
                if (!found1) begin
                    alloc1[i] = 1'b1;
                    found1    = 1'b1;
                end
`ifdef LASER_DOUBLE_SHOT_EN
                else if (!found2) begin
                    alloc2[i] = 1'b1;
                    found2    = 1'b1;
                end
`endif
            end
        end

        accept = (game_state == ST_PLAYING) && tick && fire &&
                 (cnt_q == '0) && found1;

        n_alloc = 2'd1;
`ifdef LASER_DOUBLE_SHOT_EN
        if (found2) n_alloc = 2'd2;
`endif
        fired_sum = {1'b0, fired_q} + 9'(n_alloc);

        case (game_state)
            ST_PRESS_START, ST_RESTART: begin
                valid_d = '0;
                cnt_d   = '0;
                fired_d = '0;
            end
            ST_PLAYING: begin
                for (int unsigned i = 0; i < SLOTS; i++) begin
                    if (valid_q[i]) begin
                        if (hit[i]) begin
                            valid_d[i] = 1'b0;
                        end else if (tick) begin
                            if (v_q[i] < V_W'(TOP_V + SPEED)) valid_d[i] = 1'b0;
                            else v_d[i] = v_q[i] - V_W'(SPEED);
                        end
                    end
                end
                if (tick && (cnt_q != '0)) cnt_d = cnt_q - CNT_W'(1);
                if (accept) begin
                    for (int unsigned i = 0; i < SLOTS; i++) begin
                        if (alloc1[i]) begin
                            valid_d[i] = 1'b1;
                            h_d[i]     = plane_h;
                            v_d[i]     = V_W'(START_V);
`ifdef LASER_DOUBLE_SHOT_EN
                            if (found2) h_d[i] = plane_h - H_W'(8);
`endif
                        end
`ifdef LASER_DOUBLE_SHOT_EN
                        if (alloc2[i]) begin
                            valid_d[i] = 1'b1;
                            h_d[i]     = plane_h + H_W'(8);
                            v_d[i]     = V_W'(START_V);
                        end
`endif
                    end
                    cnt_d   = CNT_W'(CD_LOAD);
                    fired_d = fired_sum[8] ? 8'hFF : fired_sum[7:0];
                end
            end
            default: ; // gameover: everything frozen
        endcase

        busy_d = (cnt_d != '0);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            h_q     <= '0;
            v_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            fired_q <= '0;
        end else begin
            valid_q <= valid_d;
            h_q     <= h_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            fired_q <= fired_d;
        end
    end

    assign laser_valid   = valid_q;
    assign laser_h       = h_q;
    assign laser_v       = v_q;
    assign cooldown_busy = busy_q;
    assign shots_fired   = fired_q;

endmodule

// File: tb/tb_laser_scheduler.sv
// tb_laser_scheduler: directed vector table plus hand-written multi-cycle
// sequences for laser_scheduler (default single-shot build).
module tb_laser_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  state;
    logic        tick;
    logic        fire;
    logic [9:0]  plane_h;
    logic [3:0]  hit;
    logic [3:0]  laser_valid;
    logic [39:0] laser_h;
    logic [35:0] laser_v;
    logic        cooldown_busy;
    logic [7:0]  shots_fired;

    int n_vec = 0;
    int n_bad = 0;

    laser_scheduler #(
        .SLOTS(4), .COOLDOWN(20), .SPEED(3), .START_V(400),
        .TOP_V(10), .H_W(10), .V_W(9)
    ) dut (
        .clk(clk), .rst_n(rst_n), .state(state), .tick(tick), .fire(fire),
        .plane_h(plane_h), .hit(hit), .laser_valid(laser_valid),
        .laser_h(laser_h), .laser_v(laser_v),
        .cooldown_busy(cooldown_busy), .shots_fired(shots_fired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic       tk;
        logic       fr;
        logic [9:0] ph;
        logic [3:0] ht;
        logic [3:0] e_valid;
        logic       e_busy;
        logic [7:0] e_fired;
        int         slot;   // -1: coordinates not checked
        logic [9:0] e_h;
        logic [8:0] e_v;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int slot_h(input int i);
        return int'(laser_h[i*10 +: 10]);
    endfunction

    function automatic int slot_v(input int i);
        return int'(laser_v[i*9 +: 9]);
    endfunction

    // Apply one cycle of inputs, then sample 1ns after the rising edge
    task automatic cyc(input logic [1:0] st, input logic tk, input logic fr,
                       input logic [9:0] ph, input logic [3:0] ht);
        state = st; tick = tk; fire = fr; plane_h = ph; hit = ht;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          st    tk    fr    ph   ht       valid    busy  fired slot h    v
        vecs[0] = '{2'd1, 1'b1, 1'b1, 145, 4'b0000, 4'b0001, 1'b1, 8'd1, 0, 145, 400};
        vecs[1] = '{2'd1, 1'b0, 1'b1, 200, 4'b0000, 4'b0001, 1'b1, 8'd1, 0, 145, 400};
        vecs[2] = '{2'd1, 1'b1, 1'b0, 200, 4'b0000, 4'b0001, 1'b1, 8'd1, 0, 145, 397};
        vecs[3] = '{2'd1, 1'b0, 1'b0, 200, 4'b0001, 4'b0000, 1'b1, 8'd1, 0, 145, 397};
        vecs[4] = '{2'd1, 1'b1, 1'b0, 200, 4'b0001, 4'b0000, 1'b1, 8'd1, 0, 145, 397};
        vecs[5] = '{2'd2, 1'b1, 1'b1, 300, 4'b1111, 4'b0000, 1'b1, 8'd1, 0, 145, 397};
        vecs[6] = '{2'd3, 1'b1, 1'b1, 300, 4'b0000, 4'b0000, 1'b0, 8'd0, -1, 0, 0};
        vecs[7] = '{2'd1, 1'b1, 1'b1, 50,  4'b0000, 4'b0001, 1'b1, 8'd1, 0, 50, 400};
        vecs[8] = '{2'd1, 1'b1, 1'b0, 60,  4'b0000, 4'b0001, 1'b1, 8'd1, 0, 50, 397};

        // Reset
        rst_n = 1'b0;
        cyc(2'd0, 1'b0, 1'b0, 10'd0, 4'b0);
        cyc(2'd0, 1'b0, 1'b0, 10'd0, 4'b0);
        chk("rst_valid", laser_valid, 0);
        chk("rst_busy", cooldown_busy, 0);
        chk("rst_fired", shots_fired, 0);
        chk("rst_h", int'(laser_h), 0);
        chk("rst_v", int'(laser_v), 0);
        rst_n = 1'b1;

        // Vector table
        for (int k = 0; k < 9; k++) begin
            cyc(vecs[k].st, vecs[k].tk, vecs[k].fr, vecs[k].ph, vecs[k].ht);
            chk($sformatf("vec%0d_valid", k), laser_valid, vecs[k].e_valid);
            chk($sformatf("vec%0d_busy", k), cooldown_busy, vecs[k].e_busy);
            chk($sformatf("vec%0d_fired", k), shots_fired, vecs[k].e_fired);
            if (vecs[k].slot >= 0) begin
                chk($sformatf("vec%0d_h", k), slot_h(vecs[k].slot), vecs[k].e_h);
                chk($sformatf("vec%0d_v", k), slot_v(vecs[k].slot), vecs[k].e_v);
            end
        end

        // Held fire, tick every cycle: accepts at 1,22,43,64; 5th waits for a slot
        cyc(2'd0, 1'b0, 1'b0, 10'd0, 4'b0);
        for (int t = 1; t <= 133; t++) begin
            cyc(2'd1, 1'b1, 1'b1, 10'(t), 4'b0);
            case (t)
                1:   chk("held_t1_fired", shots_fired, 1);
                21:  begin chk("held_t21_fired", shots_fired, 1);
                           chk("held_t21_busy", cooldown_busy, 0); end
                22:  begin chk("held_t22_fired", shots_fired, 2);
                           chk("held_t22_h1", slot_h(1), 22); end
                43:  chk("held_t43_fired", shots_fired, 3);
                64:  chk("held_t64_valid", laser_valid, 4'b1111);
                85:  begin chk("held_t85_fired", shots_fired, 4);
                           chk("held_t85_busy", cooldown_busy, 0); end
                131: begin chk("held_t131_valid", laser_valid, 4'b1111);
                           chk("held_t131_v0", slot_v(0), 10); end
                132: begin chk("held_t132_valid", laser_valid, 4'b1110);
                           chk("held_t132_fired", shots_fired, 4); end
                133: begin chk("held_t133_valid", laser_valid, 4'b1111);
                           chk("held_t133_fired", shots_fired, 5);
                           chk("held_t133_h0", slot_h(0), 133);
                           chk("held_t133_v0", slot_v(0), 400);
                           chk("held_t133_busy", cooldown_busy, 1); end
                default: ;
            endcase
        end

        // Hit on slot1 coincident with tick+fire: new shot lands in slot3
        cyc(2'd0, 1'b0, 1'b0, 10'd0, 4'b0);
        for (int t = 1; t <= 64; t++) begin
            cyc(2'd1, 1'b1, (t <= 43) || (t == 64), 10'd77,
                (t == 64) ? 4'b0010 : 4'b0000);
            if (t == 63) begin
                chk("hit_t63_valid", laser_valid, 4'b0111);
                chk("hit_t63_busy", cooldown_busy, 0);
                chk("hit_t63_v0", slot_v(0), 214);
            end
        end
        chk("hit_valid", laser_valid, 4'b1101);
        chk("hit_fired", shots_fired, 4);
        chk("hit_h3", slot_h(3), 77);
        chk("hit_v3", slot_v(3), 400);
        chk("hit_v0", slot_v(0), 211);
        chk("hit_v2", slot_v(2), 337);

        // Gameover freeze, then press_start clears
        for (int t = 0; t < 3; t++) cyc(2'd2, 1'b1, 1'b1, 10'd5, 4'b1111);
        chk("freeze_valid", laser_valid, 4'b1101);
        chk("freeze_fired", shots_fired, 4);
        chk("freeze_busy", cooldown_busy, 1);
        chk("freeze_v0", slot_v(0), 211);
        cyc(2'd0, 1'b1, 1'b1, 10'd5, 4'b0);
        chk("clr_valid", laser_valid, 0);
        chk("clr_busy", cooldown_busy, 0);
        chk("clr_fired", shots_fired, 0);

        // Saturation: constant hits free slot0 each time; accept every 21 ticks
        for (int t = 1; t <= 5360; t++) begin
            cyc(2'd1, 1'b1, 1'b1, 10'd9, 4'b1111);
            if (t == 5314) chk("sat_254", shots_fired, 254);
            if (t == 5335) chk("sat_255", shots_fired, 255);
            if (t == 5356) begin
                chk("sat_hold", shots_fired, 255);
                chk("sat_busy", cooldown_busy, 1);
            end
        end

        // Mid-operation reset
        rst_n = 1'b0;
        cyc(2'd1, 1'b1, 1'b1, 10'd9, 4'b0);
        chk("midrst_valid", laser_valid, 0);
        chk("midrst_fired", shots_fired, 0);
        chk("midrst_h", int'(laser_h), 0);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
